led_mem_ctrl: RTL

Parametrised successor of the LED state memory. It holds an N_LED-wide LED state register and a per-channel blink-mode register. Both are updated by a two-byte UART command protocol and by debounced key toggle strobes. It drives the LED port driver with the effective, blink-gated state. It sits between the UART receiver, the key driver and the LED port driver.

---
 rtl/led_mem_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/led_mem_ctrl.sv
// LED state memory: UART command FSM, key toggle path and blink-gated output register.
// Holds per-channel state and blink-mode masks and drives the LED port driver.
module led_mem_ctrl #(
  parameter int unsigned N_LED     = 6,
  parameter int unsigned BLINK_DIV = 13_500_000,
  parameter int unsigned TIMEOUT   = 1_350_000
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic [7:0]       in_uart,
  input  logic             in_uart_en,
  input  logic [N_LED-1:0] in_key,
  input  logic             in_key_en,
  output logic [N_LED-1:0] out_mem,
  output logic [N_LED-1:0] out_mode,
  output logic             out_busy,
  output logic             out_err
);

  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {StIdle, StArg} fsm_e;
  typedef enum logic [1:0] {OpSet, OpTog, OpMode} op_e;

  fsm_e             fsm_q, fsm_d;
  op_e              op_q, op_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [N_LED-1:0] state_q, state_d;
  logic [N_LED-1:0] mode_q, mode_d;
  logic             err_d;
  logic [BW-1:0]    blink_cnt_q;
  logic             phase_q;
  logic [N_LED-1:0] arg;

  assign arg      = in_uart[N_LED-1:0];
  assign out_busy = (fsm_q == StArg);

  always_comb begin
    fsm_d   = fsm_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (in_uart_en) begin
          case (in_uart)
            8'h53: begin op_d = OpSet;  tmo_d = '0; fsm_d = StArg; end
            8'h54: begin op_d = OpTog;  tmo_d = '0; fsm_d = StArg; end
            8'h4D: begin op_d = OpMode; tmo_d = '0; fsm_d = StArg; end
            8'h43: begin state_d = '0; mode_d = '0; end
            default: err_d = 1'b1;
          endcase
        end
      end
      StArg: begin
        if (in_uart_en) begin
          // Any byte here is an argument, even one that looks like an opcode.
          case (op_q)
            OpSet:   state_d = arg;
            OpTog:   state_d = state_q ^ arg;
            OpMode:  mode_d  = arg;
            default: ;
          endcase
          fsm_d = StIdle;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          op_d  = OpSet;
          fsm_d = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: fsm_d = StIdle;
    endcase
    // Key toggles land on top of whatever the UART path produced this cycle.
    if (in_key_en) state_d = state_d ^ in_key;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      fsm_q   <= StIdle;
      op_q    <= OpSet;
      tmo_q   <= '0;
      state_q <= '0;
      mode_q  <= '0;
      out_err <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      out_err <= err_d;
    end
  end

  // Free-running blink timebase; commands never touch it.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_mem  <= '0;
      out_mode <= '0;
    end else begin
      out_mem  <= state_q & (~mode_q | {N_LED{phase_q}});
      out_mode <= mode_q;
    end
  end

endmodule
